// File: rtl/arbiter_pkg.sv
// rtl/arbiter_pkg.sv - shared types, constants and helpers for the VC arbiter
//
// Contents:
//   arb_state_t  : arbiter state (IDLE, BURST)
//   MODE_RR      : prio_mode encoding for weighted round-robin
//   MODE_STRICT  : prio_mode encoding for strict priority (VC0 highest)
//   DEF_NUM_VC   : default channel count
//   DEF_WEIGHT_W : default width of one weight field
//   eff_weight() : burst length for a programmed weight (0 behaves as 1)
package arbiter_pkg;

  localparam int DEF_NUM_VC   = 4;
  localparam int DEF_WEIGHT_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam logic MODE_RR     = 1'b0;
  localparam logic MODE_STRICT = 1'b1;

  function automatic int eff_weight(input int w);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - rotating-priority find-first over a request vector
//
// Ports:
//   req   in  NUM_VC  request vector, bit i = channel i wants service
//   base  in  VC_W    index searched first; search wraps NUM_VC-1 -> 0
//   found out 1       at least one request present
//   index out VC_W    first requesting index at or after base (0 when none)
module rr_pick
  import arbiter_pkg::*;
#(
  parameter int NUM_VC = DEF_NUM_VC,
  parameter int VC_W   = $clog2(NUM_VC)
) (
  input  logic [NUM_VC-1:0] req,
  input  logic [VC_W-1:0]   base,
  output logic              found,
  output logic [VC_W-1:0]   index
);

  int pos;

  always_comb begin
    found = 1'b0;
    index = '0;
    pos   = 0;
    for (int i = 0; i < NUM_VC; i++) begin
      // Wrap by subtraction so non-power-of-two channel counts work.
      pos = int'(base) + i;
      if (pos >= NUM_VC) begin
        pos = pos - NUM_VC;
      end
      if (!found && req[VC_W'(pos)]) begin
        found = 1'b1;
        index = VC_W'(pos);
      end
    end
  end

endmodule

// File: rtl/vc_wrr_arbiter.sv
// rtl/vc_wrr_arbiter.sv - weighted round-robin / strict-priority VC pop arbiter
//
// Build option: ARB_WEIGHTED_EN
//   defined   : each round-robin grant opens a burst of eff_weight(weight) pops
//   undefined : credit register absent, weight_cfg ignored, plain round-robin
//
// Ports:
//   clk         in  1                 rising-edge clock
//   rst         in  1                 synchronous active-low reset
//   enb         in  1                 arbitration enable (0 stalls)
//   empty_vc    in  NUM_VC            per-VC FIFO empty flags
//   dest_full   in  1                 downstream full (1 stalls)
//   prio_mode   in  1                 MODE_RR or MODE_STRICT
//   weight_cfg  in  NUM_VC*WEIGHT_W   per-VC burst length, field i = VC i
//   pop_vc      out NUM_VC            one-hot pop strobe, combinational
//   grant_id    out VC_W              index of the popped VC (0 when idle)
//   grant_valid out 1                 a pop is issued this cycle
module vc_wrr_arbiter
  import arbiter_pkg::*;
#(
  parameter int NUM_VC   = DEF_NUM_VC,
  parameter int VC_W     = $clog2(NUM_VC),
  parameter int WEIGHT_W = DEF_WEIGHT_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enb,
  input  logic [NUM_VC-1:0]          empty_vc,
  input  logic                       dest_full,
  input  logic                       prio_mode,
  input  logic [NUM_VC*WEIGHT_W-1:0] weight_cfg,
  output logic [NUM_VC-1:0]          pop_vc,
  output logic [VC_W-1:0]            grant_id,
  output logic                       grant_valid
);

  arb_state_t            state;
  logic [VC_W-1:0]       cur_vc;
  logic [VC_W-1:0]       last_ptr;

  logic [NUM_VC-1:0]     req;
  logic                  go;
  logic                  cont;
  logic [VC_W-1:0]       rr_base;
  logic                  rr_found;
  logic [VC_W-1:0]       rr_idx;
  logic                  st_found;
  logic [VC_W-1:0]       st_idx;
  logic                  pop_en;
  logic [VC_W-1:0]       pop_idx;

  assign req = ~empty_vc;
  // Reset is folded into go so nothing pops while rst is low.
  assign go  = rst & enb & ~dest_full;

  // Round-robin search starts just after the last served VC.
  assign rr_base = (last_ptr == VC_W'(NUM_VC - 1)) ? '0 : last_ptr + 1'b1;

  rr_pick #(.NUM_VC(NUM_VC), .VC_W(VC_W)) u_rr_pick (
    .req   (req),
    .base  (rr_base),
    .found (rr_found),
    .index (rr_idx)
  );

  rr_pick #(.NUM_VC(NUM_VC), .VC_W(VC_W)) u_strict_pick (
    .req   (req),
    .base  ('0),
    .found (st_found),
    .index (st_idx)
  );

`ifdef ARB_WEIGHTED_EN
  logic [WEIGHT_W-1:0] credit;
  logic [WEIGHT_W-1:0] load_credit;

  // Burst continues only while the VC still has data and credit remains.
  assign cont        = (state == BURST) && req[cur_vc] && (credit != '0);
  assign load_credit = WEIGHT_W'(eff_weight(int'(weight_cfg[int'(rr_idx)*WEIGHT_W +: WEIGHT_W])) - 1);
`else
  logic unused_cfg;

  assign cont       = 1'b0;
  assign unused_cfg = ^{weight_cfg, cur_vc, state};
`endif

  always_comb begin
    pop_en  = 1'b0;
    pop_idx = '0;
    if (go) begin
      if (prio_mode == MODE_STRICT) begin
        pop_en  = st_found;
        pop_idx = st_idx;
      end else if (cont) begin
        pop_en  = 1'b1;
        pop_idx = cur_vc;
      end else begin
        pop_en  = rr_found;
        pop_idx = rr_idx;
      end
    end
  end

  assign pop_vc      = pop_en ? ({{(NUM_VC-1){1'b0}}, 1'b1} << pop_idx) : '0;
  assign grant_id    = pop_idx;
  assign grant_valid = pop_en;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      cur_vc   <= '0;
      last_ptr <= VC_W'(NUM_VC - 1);
`ifdef ARB_WEIGHTED_EN
      credit   <= '0;
`endif
    end else if (go) begin
      if (prio_mode == MODE_STRICT) begin
        // Strict mode never holds a burst open; a return to RR starts fresh.
        if (st_found) begin
          last_ptr <= st_idx;
        end
        state <= IDLE;
`ifdef ARB_WEIGHTED_EN
        credit <= '0;
`endif
      end else if (cont) begin
        state <= BURST;
`ifdef ARB_WEIGHTED_EN
        credit <= credit - 1'b1;
`endif
      end else if (rr_found) begin
        state    <= BURST;
        cur_vc   <= rr_idx;
        last_ptr <= rr_idx;
`ifdef ARB_WEIGHTED_EN
        credit   <= load_credit;
`endif
      end else begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_vc_wrr_arbiter.sv
// tb/tb_vc_wrr_arbiter.sv - self-checking bench for vc_wrr_arbiter
module tb_vc_wrr_arbiter;

  localparam int N  = 4;
  localparam int WW = 3;
  localparam int VW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          enb;
  logic [N-1:0]  empty_vc;
  logic          dest_full;
  logic          prio_mode;
  logic [N*WW-1:0] weight_cfg;
  logic [N-1:0]  pop_vc;
  logic [VW-1:0] grant_id;
  logic          grant_valid;

  int checks = 0;
  int errors = 0;

  // Reference model: last served VC, VC of the open burst (-1 none),
  // pops still owed to that burst.
  int m_last = N - 1;
  int m_bvc  = -1;
  int m_rem  = 0;

  always #5 clk = ~clk;

  vc_wrr_arbiter #(.NUM_VC(N), .VC_W(VW), .WEIGHT_W(WW)) dut (
    .clk         (clk),
    .rst         (rst),
    .enb         (enb),
    .empty_vc    (empty_vc),
    .dest_full   (dest_full),
    .prio_mode   (prio_mode),
    .weight_cfg  (weight_cfg),
    .pop_vc      (pop_vc),
    .grant_id    (grant_id),
    .grant_valid (grant_valid)
  );

  function automatic int wt(input int v);
`ifdef ARB_WEIGHTED_EN
    int f;
    f = int'(weight_cfg[v*WW +: WW]);
    return (f == 0) ? 1 : f;
`else
    return (v >= 0) ? 1 : 1;
`endif
  endfunction

  function automatic bit m_cont();
    return (m_bvc >= 0) && !empty_vc[m_bvc] && (m_rem > 0);
  endfunction

  function automatic int m_pick();
    int v;
    if (!rst || !enb || dest_full) return -1;
    if (prio_mode) begin
      for (int i = 0; i < N; i++) if (!empty_vc[i]) return i;
      return -1;
    end
    if (m_cont()) return m_bvc;
    for (int k = 1; k <= N; k++) begin
      v = (m_last + k) % N;
      if (!empty_vc[v]) return v;
    end
    return -1;
  endfunction

  task automatic m_commit();
    int p;
    bit c;
    p = m_pick();
    c = m_cont();
    if (!rst) begin
      m_last = N - 1;
      m_bvc  = -1;
      m_rem  = 0;
    end else if (enb && !dest_full) begin
      if (prio_mode) begin
        if (p >= 0) m_last = p;
        m_bvc = -1;
        m_rem = 0;
      end else if (c) begin
        m_rem = m_rem - 1;
      end else if (p >= 0) begin
        m_last = p;
        m_bvc  = p;
        m_rem  = wt(p) - 1;
      end else begin
        m_bvc = -1;
      end
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at the falling edge after inputs are driven; checks outputs
  // against the model, advances the model, then moves to the next falling edge.
  task automatic step(output int g);
    int p;
    #1;
    p = m_pick();
    g = grant_valid ? int'(grant_id) : -1;
    chk("pop_vc", int'(pop_vc), (p >= 0) ? (1 << p) : 0);
    chk("grant_id", int'(grant_id), (p >= 0) ? p : 0);
    chk("grant_valid", int'(grant_valid), (p >= 0) ? 1 : 0);
    m_commit();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int g;
    int seq[$];
`ifdef ARB_WEIGHTED_EN
    seq = '{0, 1, 1, 1, 2, 2, 3};
`else
    seq = '{0, 1, 2, 3};
`endif
    rst        = 1'b0;
    enb        = 1'b1;
    dest_full  = 1'b0;
    prio_mode  = 1'b0;
    empty_vc   = '0;
    weight_cfg = {3'd1, 3'd2, 3'd3, 3'd1};
    @(negedge clk);

    repeat (3) begin
      step(g);
      chk("reset_pop", g, -1);
    end
    rst = 1'b1;
    step(g);
    chk("first_after_reset", g, 0);

    for (int i = 1; i < 2 * seq.size(); i++) begin
      step(g);
      chk("wrr_order", g, seq[i % seq.size()]);
    end

    step(g);
    chk("next_round_vc0", g, 0);
    step(g);
    chk("burst_start_vc1", g, 1);
    empty_vc = 4'b0010;
    step(g);
    chk("early_end", g, 2);

    empty_vc  = '0;
    dest_full = 1'b1;
    repeat (2) begin
      step(g);
      chk("stall", g, -1);
    end
    dest_full = 1'b0;
    step(g);
`ifdef ARB_WEIGHTED_EN
    chk("resume", g, 2);
`else
    chk("resume", g, 3);
`endif

    prio_mode = 1'b1;
    empty_vc  = 4'b1010;
    repeat (3) begin
      step(g);
      chk("strict_vc0", g, 0);
    end
    empty_vc = 4'b1011;
    step(g);
    chk("strict_vc2", g, 2);

    prio_mode = 1'b0;
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++) empty_vc[i] = ($urandom_range(0, 3) == 0);
      dest_full = ($urandom_range(0, 4) == 0);
      enb       = ($urandom_range(0, 7) != 0);
      rst       = ($urandom_range(0, 63) != 0);
      if ($urandom_range(0, 23) == 0) prio_mode = ~prio_mode;
      if ($urandom_range(0, 15) == 0) weight_cfg = (N*WW)'($urandom);
      step(g);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
